// File: rtl/dac714_serial_tx.sv
// dac714_serial_tx: parallel DAC word to DAC714 serial frame (MSB-first).
// Ports:
//   clk, nReset       clock, async active-low reset
//   dac_strobe        rising edge requests one frame
//   dac_out           word captured on the request cycle
//   clr_overrun       sync clear of the sticky overrun flag
//   sclk, sdi         serial clock/data (DAC samples on sclk rise)
//   nlatch            active-low latch pulse after the last bit
//   busy              frame in progress or word pending
//   overrun           a pending word was overwritten
// Option: define DAC714_STROBE_SYNC_EN to pass dac_strobe through a
// 2-flop synchronizer (adds 2 cycles of request latency).
module dac714_serial_tx #(
  parameter int DAC_WIDTH    = 16,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 dac_strobe,
  input  logic [DAC_WIDTH-1:0] dac_out,
  input  logic                 clr_overrun,
  output logic                 sclk,
  output logic                 sdi,
  output logic                 nlatch,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DAC_WIDTH);
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DAC_WIDTH - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t               state_q, state_d;
  logic [DAC_WIDTH-1:0] sh_q, sh_d;
  logic [DAC_WIDTH-1:0] pend_q, pend_d;
  logic                 pv_q, pv_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [CW-1:0]        div_q, div_d;
  logic [LW-1:0]        lat_q, lat_d;
  logic                 sclk_q, sclk_d;
  logic                 ovr_q, ovr_d;
  logic                 strobe_s, strobe_q;
  logic                 req;
  logic                 consume;
  logic                 direct;

`ifdef DAC714_STROBE_SYNC_EN
  // Reset high so a strobe already high at release is not an edge.
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], dac_strobe};
  end

  assign strobe_s = sync_q[1];
`else
  assign strobe_s = dac_strobe;
`endif

  // Reset high: only a low-to-high transition after reset counts.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) strobe_q <= 1'b1;
    else         strobe_q <= strobe_s;
  end

  assign req    = strobe_s & ~strobe_q;
  assign direct = (state_q == S_IDLE) & ~pv_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    bit_d   = bit_q;
    div_d   = div_q;
    lat_d   = lat_q;
    sclk_d  = sclk_q;
    ovr_d   = ovr_q;
    consume = 1'b0;

    if (clr_overrun) ovr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pv_q || req) begin
          sh_d    = pv_q ? pend_q : dac_out;
          consume = pv_q;
          bit_d   = BIT_LAST;
          div_d   = '0;
          sclk_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            sh_d   = {sh_q[DAC_WIDTH-2:0], 1'b0};
            if (bit_q == '0) begin
              lat_d   = '0;
              state_d = S_LATCH;
            end else begin
              bit_d = bit_q - BW'(1);
            end
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (lat_q == LAT_LAST) begin
          // A pending word chains straight into the next frame.
          if (pv_q) begin
            sh_d    = pend_q;
            consume = 1'b1;
            bit_d   = BIT_LAST;
            div_d   = '0;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (consume) pv_d = 1'b0;

    // A word consumed this cycle is not an overrun victim.
    if (req && !direct) begin
      pend_d = dac_out;
      pv_d   = 1'b1;
      if (pv_q && !consume) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      bit_q   <= '0;
      div_q   <= '0;
      lat_q   <= '0;
      sclk_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      lat_q   <= lat_d;
      sclk_q  <= sclk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sclk    = sclk_q;
  assign sdi     = (state_q == S_SHIFT) & sh_q[DAC_WIDTH-1];
  assign nlatch  = (state_q != S_LATCH);
  assign busy    = (state_q != S_IDLE) | pv_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_dac714_serial_tx.sv
// tb_dac714_serial_tx: directed + random frames vs. a word-level model.
// Frames are rebuilt from sclk/sdi and compared with predicted words.
module tb_dac714_serial_tx;

  localparam int W     = 16;
  localparam int DIV   = 4;
  localparam int LAT   = 2;
  localparam int FRAME = 2 * DIV * W + LAT;
`ifdef DAC714_STROBE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic         clk;
  logic         nReset;
  logic         dac_strobe;
  logic [W-1:0] dac_out;
  logic         clr_overrun;
  logic         sclk, sdi, nlatch, busy, overrun;

  dac714_serial_tx #(
    .DAC_WIDTH   (W),
    .CLK_DIV     (DIV),
    .LATCH_CYCLES(LAT)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .dac_strobe (dac_strobe),
    .dac_out    (dac_out),
    .clr_overrun(clr_overrun),
    .sclk       (sclk),
    .sdi        (sdi),
    .nlatch     (nlatch),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] cur = '0;
  logic [W-1:0] rx_q[$];
  int first_rise_q[$];
  int nl_rise_q[$];
  int nb = 0, rises = 0, nl_falls = 0, nl_fall = 0, nl_run = 0, nl_len = 0;
  int busy_start = 0, b_run = 0, busy_len = 0, busy_cyc = 0;
  logic p_sclk = 1'b0, p_nl = 1'b1, p_busy = 1'b0;

  always @(negedge clk) begin
    if (!nReset) begin
      nb = 0;
      cur = '0;
      p_sclk = 1'b0;
      p_nl = 1'b1;
      p_busy = 1'b0;
    end else begin
      if (sclk && !p_sclk) begin
        if (nb == 0) first_rise_q.push_back(cyc);
        cur = {cur[W-2:0], sdi};
        nb++;
        rises++;
        if (nb == W) begin
          rx_q.push_back(cur);
          nb = 0;
        end
      end
      if (!nlatch && p_nl) begin
        nl_falls++;
        nl_fall = cyc;
        nl_run = 0;
      end
      if (!nlatch) nl_run++;
      if (nlatch && !p_nl) begin
        nl_len = nl_run;
        nl_rise_q.push_back(cyc);
      end
      if (busy && !p_busy) begin
        busy_start = cyc;
        b_run = 0;
      end
      if (busy) begin
        b_run++;
        busy_cyc++;
      end
      if (!busy && p_busy) busy_len = b_run;
      p_sclk = sclk;
      p_nl = nlatch;
      p_busy = busy;
    end
  end

  // ---------------- reference model ----------------
  // Word-level: one frame occupies FRAME cycles after its detect cycle;
  // requests inside a frame go to a single pending slot.
  logic [W-1:0] exp_q[$];
  int           m_until = -1000;
  bit           m_pv = 1'b0;
  logic [W-1:0] m_pw = '0;
  int           m_pt = 0;
  bit           m_ovr = 1'b0;

  task automatic m_launch();
    int lt;
    lt = (m_pt == m_until) ? m_until + 1 : m_until;
    exp_q.push_back(m_pw);
    m_until = lt + FRAME;
    m_pv = 1'b0;
  endtask

  task automatic m_req(input logic [W-1:0] w, input int u);
    if (m_pv && m_until < u) m_launch();
    if (m_pv && m_until == u && m_pt < u) m_launch();
    if (u > m_until && !m_pv) begin
      exp_q.push_back(w);
      m_until = u + FRAME;
    end else begin
      if (m_pv) m_ovr = 1'b1;
      m_pw = w;
      m_pv = 1'b1;
      m_pt = u;
    end
  endtask

  task automatic m_reset();
    m_until = -1000;
    m_pv = 1'b0;
    m_ovr = 1'b0;
    exp_q.delete();
    rx_q.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  int t_str;

  task automatic strobe(input logic [W-1:0] w, input int len);
    @(posedge clk);
    #1;
    dac_out = w;
    dac_strobe = 1'b1;
    t_str = cyc;
    m_req(w, cyc + SL);
    repeat (len) @(posedge clk);
    #1;
    dac_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n;
    n = 0;
    repeat (SL + 3) @(negedge clk);
    while (busy !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(tag, busy, 0);
  endtask

  task automatic cmp_words(input string tag);
    if (m_pv) m_launch();
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_ovr();
    @(posedge clk);
    #1 clr_overrun = 1'b1;
    @(posedge clk);
    #1 clr_overrun = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    chk("clr_overrun", overrun, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int r0, nlf, bc, n, len, gap;
    nReset = 1'b0;
    dac_strobe = 1'b0;
    dac_out = '0;
    clr_overrun = 1'b0;
    #23;
    chk("rst_sclk", sclk, 0);
    chk("rst_sdi", sdi, 0);
    chk("rst_nlatch", nlatch, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk);
    #1 nReset = 1'b1;
    repeat (3) @(posedge clk);

    // single frame 0x8001
    first_rise_q.delete();
    nl_rise_q.delete();
    r0 = rises;
    strobe(16'h8001, 10);
    wait_idle("t1_idle", 400);
    chk("t1_rises", rises - r0, W);
    chk("t1_busy_start", busy_start, t_str + 1 + SL);
    chk("t1_first_rise", first_rise_q[0], t_str + 1 + SL + DIV);
    chk("t1_busy_len", busy_len, FRAME);
    chk("t1_nl_len", nl_len, LAT);
    chk("t1_nl_fall", nl_fall, busy_start + 2 * DIV * W);
    chk("t1_overrun", overrun, m_ovr);
    chk("t1_sdi_idle", sdi, 0);
    cmp_words("t1");

    // long strobe level: one frame only
    strobe(16'h1234, 500);
    wait_idle("t2_idle", 400);
    cmp_words("t2");

    // back-to-back frames
    first_rise_q.delete();
    nl_rise_q.delete();
    strobe(16'h00FF, 5);
    repeat (14) @(posedge clk);
    strobe(16'hFF00, 5);
    wait_idle("t3_idle", 600);
    chk("t3_busy_len", busy_len, 2 * FRAME);
    chk("t3_gap", first_rise_q[1], nl_rise_q[0] + DIV);
    chk("t3_overrun", overrun, m_ovr);
    cmp_words("t3");

    // overrun: three requests inside one frame
    strobe(16'h0001, 3);
    repeat (16) @(posedge clk);
    strobe(16'h0002, 3);
    repeat (16) @(posedge clk);
    strobe(16'h0003, 3);
    wait_idle("t4_idle", 600);
    chk("t4_overrun", overrun, m_ovr);
    cmp_words("t4");
    clear_ovr();

    // reset mid-frame, release with strobe high
    r0 = rises;
    strobe(16'hABCD, 3);
    n = 0;
    while (rises < r0 + 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rises", rises - r0, 7);
    nlf = nl_falls;
    #2 nReset = 1'b0;
    #1;
    chk("t5_sclk", sclk, 0);
    chk("t5_sdi", sdi, 0);
    chk("t5_nlatch", nlatch, 1);
    chk("t5_busy", busy, 0);
    chk("t5_overrun", overrun, 0);
    m_reset();
    dac_out = 16'h5555;
    dac_strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 nReset = 1'b1;
    bc = busy_cyc;
    repeat (200) @(posedge clk);
    chk("t5_no_frame", busy_cyc - bc, 0);
    chk("t5_no_latch", nl_falls - nlf, 0);
    chk("t5_no_word", rx_q.size(), 0);
    #1 dac_strobe = 1'b0;
    repeat (2) @(posedge clk);
    strobe(16'h5555, 4);
    wait_idle("t5_idle", 400);
    cmp_words("t5");

    // random requests against the model
    for (int i = 0; i < 25; i++) begin
      len = $urandom_range(1, 3);
      gap = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 60)
                                        : $urandom_range(100, 300);
      strobe(W'($urandom), len);
      repeat (gap) @(posedge clk);
    end
    wait_idle("rnd_idle", 1000);
    chk("rnd_overrun", overrun, m_ovr);
    cmp_words("rnd");
    clear_ovr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
